// File: rtl/gen_stream_pacer.sv
// Ingress pacer for the generator: buffers pixels in a FIFO and re-emits them as
// single-cycle pulses separated by programmable pixel/row gaps, tracking row/column.
module gen_stream_pacer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ROW_LEN    = 8,
  parameter int NUM_ROWS   = 8,
  parameter int GAP_W      = 16,
  localparam int COL_W     = (ROW_LEN  > 1) ? $clog2(ROW_LEN)  : 1,
  localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [GAP_W-1:0]             cfg_pix_gap,
  input  logic [GAP_W-1:0]             cfg_row_gap,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic                         m_valid,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic [COL_W-1:0]             m_col,
  output logic [ROW_W-1:0]             m_row,
  output logic                         busy,
  output logic                         frame_done,
  output logic [1:0]                   dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Handshake: a pixel transfers on every rising edge where s_valid && s_ready;
  // s_ready is registered and never depends on s_valid. m_valid is a
  // one-cycle pulse with no back-pressure from the consumer.

  logic signed [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]             r_count;
  logic                         r_s_ready;

  state_t                       r_state;
  logic [GAP_W-1:0]             r_gap_len;
  logic [GAP_W-1:0]             r_gap_cnt;
  logic                         r_last_frame;
  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             r_row;
  logic                         r_m_valid;
  logic signed [DATA_WIDTH-1:0] r_m_data;
  logic [COL_W-1:0]             r_m_col;
  logic [ROW_W-1:0]             r_m_row;
  logic                         r_frame_done;

  logic                         w_push;
  logic                         w_pop;
  logic                         w_avail;
  logic                         w_slot_free;
  logic                         w_start;
  logic                         w_col_last;
  logic                         w_row_last;
  logic [GAP_W-1:0]             w_gap_sel;
  logic [CNT_W-1:0]             w_next_count;

  assign w_push     = s_valid && r_s_ready;
  assign w_avail    = en && (r_count != '0);
  assign w_col_last = (r_col == COL_W'(ROW_LEN - 1));
  assign w_row_last = (r_row == ROW_W'(NUM_ROWS - 1));
  assign w_gap_sel  = w_col_last ? cfg_row_gap : cfg_pix_gap;

  // A new pulse may start once the previous pulse and its whole gap are over.
  always_comb begin
    w_slot_free = 1'b0;
    case (r_state)
      ST_IDLE: w_slot_free = 1'b1;
      ST_EMIT: w_slot_free = (r_gap_len == '0);
      ST_GAP:  w_slot_free = (r_gap_cnt == '0);
      default: w_slot_free = 1'b0;
    endcase
  end

  assign w_start = w_avail && w_slot_free;
  assign w_pop   = w_start;

  always_comb begin
    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + CNT_W'(1);
      2'b01:   w_next_count = r_count - CNT_W'(1);
      default: w_next_count = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count   <= w_next_count;
      r_s_ready <= (w_next_count < CNT_W'(FIFO_DEPTH));
    end
  end

  // The pop, data capture, position advance and gap latch all happen on the
  // edge that enters EMIT, so the EMIT cycle itself carries the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gap_len    <= '0;
      r_gap_cnt    <= '0;
      r_last_frame <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_col      <= '0;
      r_m_row      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_m_valid    <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
        end
        ST_EMIT: begin
          if (r_gap_len != '0) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= r_gap_len - GAP_W'(1);
          end else begin
            r_frame_done <= r_last_frame;
            if (!w_start) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_frame_done <= r_last_frame;
            if (!w_start) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_start) begin
        r_state      <= ST_EMIT;
        r_m_valid    <= 1'b1;
        r_m_data     <= r_mem[r_rd_ptr];
        r_m_col      <= r_col;
        r_m_row      <= r_row;
        r_gap_len    <= w_gap_sel;
        r_last_frame <= w_col_last && w_row_last;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_col      = r_m_col;
  assign m_row      = r_m_row;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_IDLE) || (r_count != '0);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_gen_stream_pacer.sv
// Bench for gen_stream_pacer: scripted scenarios plus random traffic, checked every
// cycle against a timing/position model derived from the pacing rules.
module tb_gen_stream_pacer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int RL    = 8;
  localparam int NR    = 2;
  localparam int GW    = 16;
  localparam int FRAME = RL * NR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [GW-1:0] cfg_pix_gap = '0;
  logic [GW-1:0] cfg_row_gap = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [2:0]    m_col;
  logic [0:0]    m_row;
  logic          busy;
  logic          frame_done;
  logic [1:0]    dbg_state;

  gen_stream_pacer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ROW_LEN(RL), .NUM_ROWS(NR), .GAP_W(GW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_pix_gap(cfg_pix_gap), .cfg_row_gap(cfg_row_gap),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_data(m_data), .m_col(m_col), .m_row(m_row),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // A queued pixel is emitted at the first cycle t with t >= handshake+2,
  // t >= previous pulse + gap + 1, and en high in cycle t-1.
  logic [DW-1:0] exp_q[$];
  int            hs_q[$];
  int            pulse_idx = 0;
  bit            have_prev = 0;
  int            prev_t = 0;
  int            prev_g = 0;
  int            fd_due = -1;
  logic [DW-1:0] last_data = '0;
  bit            just_reset = 1;
  logic          en_prev = 1'b0;
  logic [GW-1:0] pix_prev = '0;
  logic [GW-1:0] row_prev = '0;
  int            accepted = 0;
  int            n_pulses = 0;
  int            fd_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hs_q.delete();
      pulse_idx  = 0;
      have_prev  = 0;
      fd_due     = -1;
      last_data  = '0;
      just_reset = 1;
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_m_col", m_col, 0);
      check_eq("rst_m_row", m_row, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_s_ready", s_ready, 0);
      check_eq("rst_state", dbg_state, 0);
    end else begin
      bit exp_pulse;
      int earliest;
      exp_pulse = 0;
      if (exp_q.size() > 0 && en_prev) begin
        earliest = hs_q[0] + 2;
        if (have_prev && (prev_t + prev_g + 1 > earliest)) earliest = prev_t + prev_g + 1;
        if (cyc >= earliest) exp_pulse = 1;
      end
      check_eq("m_valid", m_valid, exp_pulse);
      if (exp_pulse) begin
        logic [DW-1:0] d;
        int col, row, g;
        d   = exp_q.pop_front();
        void'(hs_q.pop_front());
        col = pulse_idx % RL;
        row = (pulse_idx / RL) % NR;
        g   = (col == RL - 1) ? int'(row_prev) : int'(pix_prev);
        check_eq("m_data", m_data, d);
        check_eq("m_col", m_col, col);
        check_eq("m_row", m_row, row);
        if ((pulse_idx % FRAME) == FRAME - 1) fd_due = cyc + g + 1;
        pulse_idx++;
        have_prev = 1;
        prev_t    = cyc;
        prev_g    = g;
        last_data = d;
        n_pulses++;
      end else begin
        check_eq("m_data_hold", m_data, last_data);
      end
      check_eq("frame_done", frame_done, (cyc == fd_due));
      if (frame_done) fd_seen++;
      check_eq("busy", busy, (exp_q.size() > 0) || (have_prev && cyc <= prev_t + prev_g));
      check_eq("s_ready", s_ready, just_reset ? 0 : (exp_q.size() < DEPTH));
      just_reset = 0;
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        hs_q.push_back(cyc);
        accepted++;
      end
    end
    en_prev  = en;
    pix_prev = cfg_pix_gap;
    row_prev = cfg_row_gap;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit ok;
    ok      = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_eq("idle_wait_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int p0, f0, a0;
    step(3);
    rst = 1'b0;
    step(2);

    // pacing of one row: pixel gap 3, row gap 20
    cfg_pix_gap = 16'd3;
    cfg_row_gap = 16'd20;
    en = 1'b1;
    p0 = n_pulses;
    for (int v = -5; v <= 2; v++) send(DW'(v));
    wait_idle(200);
    check_eq("t1_pulses", n_pulses - p0, 8);

    // second row closes the frame; frame_done after the flush gap
    p0 = n_pulses;
    f0 = fd_seen;
    for (int i = 0; i < 8; i++) send(DW'($urandom));
    wait_idle(300);
    check_eq("t4_pulses", n_pulses - p0, 8);
    check_eq("t4_frame_done_count", fd_seen - f0, 1);
    send(16'h1234);
    wait_idle(100);

    // zero gap: preloaded pixels leave on consecutive cycles
    cfg_pix_gap = 16'd0;
    cfg_row_gap = 16'd0;
    en = 1'b0;
    send(16'd10); send(16'd20); send(16'd30); send(16'd40);
    step(3);
    p0 = n_pulses;
    en = 1'b1;
    wait_idle(50);
    check_eq("t2_pulses", n_pulses - p0, 4);

    // fill to capacity with emission halted
    cfg_pix_gap = 16'd1;
    cfg_row_gap = 16'd2;
    en = 1'b0;
    a0 = accepted;
    p0 = n_pulses;
    fork
      begin
        for (int i = 0; i < 20; i++) send(DW'($urandom));
      end
      begin
        step(30);
        check_eq("t3_accepted_full", accepted - a0, DEPTH);
        check_eq("t3_s_ready_full", s_ready, 0);
        en = 1'b1;
      end
    join
    wait_idle(300);
    check_eq("t3_accepted_all", accepted - a0, 20);
    check_eq("t3_pulses", n_pulses - p0, 20);

    // asynchronous reset in the middle of a gap with entries queued
    cfg_pix_gap = 16'd5;
    cfg_row_gap = 16'd5;
    en = 1'b0;
    for (int i = 0; i < 6; i++) send(DW'($urandom));
    en = 1'b1;
    step(3);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_async_m_valid", m_valid, 0);
    check_eq("t5_async_m_data", m_data, 0);
    check_eq("t5_async_busy", busy, 0);
    check_eq("t5_async_s_ready", s_ready, 0);
    step(2);
    rst = 1'b0;
    step(2);
    check_eq("t5_busy_after", busy, 0);
    send(16'h0BEE);
    wait_idle(50);

    // en dropped mid-gap: gap completes, emission resumes at column 3
    cfg_pix_gap = 16'd10;
    cfg_row_gap = 16'd10;
    fork
      begin
        send(16'h0011); send(16'h0022); send(16'h0033);
      end
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (m_valid && m_col == 3'd2) break;
        end
        check_eq("t6_col2_seen", m_col, 2);
        step(3);
        en = 1'b0;
        step(20);
        en = 1'b1;
      end
    join
    wait_idle(100);

    // random traffic, random enable and configuration
    for (int i = 0; i < 1500; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      en      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) cfg_pix_gap = GW'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) cfg_row_gap = GW'($urandom_range(0, 6));
      step(1);
    end
    s_valid = 1'b0;
    en = 1'b1;
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
